// File: rtl/fast_frame_ctrl_pkg.sv
// Shared definitions for the FAST frame sequencer: FSM state encoding,
// default frame geometry and a counter-width helper.
package fast_frame_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ARM   = 3'd1,
        ST_RUN   = 3'd2,
        ST_FLUSH = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    // Geometry shared with the window generator and NMS stages.
    localparam int DEF_COL_NUM     = 640;
    localparam int DEF_ROW_NUM     = 480;
    localparam int DEF_PIXEL_WIDTH = 8;

    // Bits needed to hold values 0..range-1, never less than one bit.
    function automatic int cnt_width(input int range);
        return (range > 1) ? $clog2(range) : 1;
    endfunction

endpackage

// File: rtl/fast_frame_ctrl_cnt.sv
// Column/row position counter for the pixel stream. It holds the position of
// the next beat expected; 'first' accounts for pixel (0,0) from any position.
module fast_frame_ctrl_cnt
    import fast_frame_ctrl_pkg::*;
#(
    parameter int COL_NUM = DEF_COL_NUM,
    parameter int ROW_NUM = DEF_ROW_NUM
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic first,
    input  logic en,
    output logic col_last,
    output logic frame_last
);

    localparam int CW = cnt_width(COL_NUM);
    localparam int RW = cnt_width(ROW_NUM);

    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic [CW-1:0] col_base;
    logic [RW-1:0] row_base;

    // A start-of-frame beat counts as if the counter had been at (0,0).
    always_comb begin
        col_base = first ? '0 : col;
        row_base = first ? '0 : row;
    end

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            col <= '0;
            row <= '0;
        end else if (first || en) begin
            if (col_base == CW'(COL_NUM - 1)) begin
                col <= '0;
                row <= (row_base == RW'(ROW_NUM - 1)) ? '0 : row_base + RW'(1);
            end else begin
                col <= col_base + CW'(1);
            end
        end
    end

    assign col_last   = (col == CW'(COL_NUM - 1));
    assign frame_last = col_last && (row == RW'(ROW_NUM - 1));

endmodule

// File: rtl/fast_frame_ctrl.sv
// Frame sequencer in front of the FAST 7x7 window generator: locks onto SOF,
// checks framing, honours backpressure and flushes the pipeline with zeros.
module fast_frame_ctrl
    import fast_frame_ctrl_pkg::*;
#(
    parameter int COL_NUM      = DEF_COL_NUM,
    parameter int ROW_NUM      = DEF_ROW_NUM,
    parameter int PIXEL_WIDTH  = DEF_PIXEL_WIDTH,
    parameter int FLUSH_CYCLES = 3 * COL_NUM + 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   abort,
    input  logic                   cont,
    input  logic [PIXEL_WIDTH-1:0] s_data,
    input  logic                   s_valid,
    input  logic                   s_sof,
    input  logic                   s_eol,
    output logic                   s_ready,
    input  logic                   ds_ready,
    output logic                   ce,
    output logic [PIXEL_WIDTH-1:0] pix_out,
    output logic                   pipe_rst,
    output logic                   busy,
    output logic                   frame_done,
    output logic                   err_len,
    output logic                   err_sof,
    output logic [2:0]             state_dbg
);

    localparam int FW       = cnt_width(FLUSH_CYCLES);
    localparam bit ONE_PIX  = (COL_NUM * ROW_NUM == 1);

    state_t        state;
    logic [FW-1:0] flush_cnt;
    logic          cnt_first;
    logic          cnt_en;
    logic          cnt_clr;
    logic          col_last;
    logic          frame_last;

    // Handshake: a DMA beat transfers on a cycle where s_valid && s_ready.
    // s_ready never depends on s_valid; ce marks a cycle in which the window
    // generator advances, which requires ds_ready and, in ARM/RUN, a beat.
    always_comb begin
        s_ready = 1'b0;
        ce      = 1'b0;
        pix_out = '0;
        case (state)
            ST_ARM: begin
                s_ready = ds_ready;
                ce      = s_valid && s_sof && ds_ready;
            end
            ST_RUN: begin
                s_ready = ds_ready;
                ce      = s_valid && ds_ready;
            end
            ST_FLUSH: ce = ds_ready;
            default: ;
        endcase
        if ((state == ST_ARM || state == ST_RUN) && ce)
            pix_out = s_data;
    end

    assign cnt_first = (state == ST_ARM) && ce;
    assign cnt_en    = (state == ST_RUN) && ce;
    assign cnt_clr   = abort || (state == ST_IDLE);
    assign state_dbg = state;

    fast_frame_ctrl_cnt #(
        .COL_NUM (COL_NUM),
        .ROW_NUM (ROW_NUM)
    ) u_cnt (
        .clk        (clk),
        .rst        (rst),
        .clr        (cnt_clr),
        .first      (cnt_first),
        .en         (cnt_en),
        .col_last   (col_last),
        .frame_last (frame_last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            flush_cnt  <= '0;
            pipe_rst   <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            err_len    <= 1'b0;
            err_sof    <= 1'b0;
        end else begin
            pipe_rst   <= 1'b0;
            frame_done <= 1'b0;
            if (abort) begin
                // Error flags survive an abort so software can inspect them.
                state     <= ST_IDLE;
                busy      <= 1'b0;
                flush_cnt <= '0;
                pipe_rst  <= 1'b1;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (start) begin
                            state    <= ST_ARM;
                            busy     <= 1'b1;
                            pipe_rst <= 1'b1;
                            err_len  <= 1'b0;
                            err_sof  <= 1'b0;
                        end
                    end
                    ST_ARM: begin
                        if (ce) begin
                            if (ONE_PIX) begin
                                state     <= ST_FLUSH;
                                flush_cnt <= FW'(FLUSH_CYCLES - 1);
                            end else begin
                                state <= ST_RUN;
                            end
                        end
                    end
                    ST_RUN: begin
                        if (ce) begin
                            // Counters define framing; markers are only checked.
                            if (s_eol != col_last)
                                err_len <= 1'b1;
                            if (s_sof)
                                err_sof <= 1'b1;
                            if (frame_last) begin
                                state     <= ST_FLUSH;
                                flush_cnt <= FW'(FLUSH_CYCLES - 1);
                            end
                        end
                    end
                    ST_FLUSH: begin
                        if (ce) begin
                            if (flush_cnt == '0) begin
                                state      <= ST_DONE;
                                frame_done <= 1'b1;
                            end else begin
                                flush_cnt <= flush_cnt - FW'(1);
                            end
                        end
                    end
                    ST_DONE: begin
                        if (cont) begin
                            state <= ST_ARM;
                        end else begin
                            state <= ST_IDLE;
                            busy  <= 1'b0;
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fast_frame_ctrl.sv
// Randomised bench for fast_frame_ctrl on an 8x6 frame with a 30-cycle flush.
module tb_fast_frame_ctrl;

    localparam int COL   = 8;
    localparam int ROW   = 6;
    localparam int FLUSH = 30;
    localparam int PW    = 8;
    localparam int NPIX  = COL * ROW;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          abort;
    logic          cont;
    logic [PW-1:0] s_data;
    logic          s_valid;
    logic          s_sof;
    logic          s_eol;
    logic          s_ready;
    logic          ds_ready;
    logic          ce;
    logic [PW-1:0] pix_out;
    logic          pipe_rst;
    logic          busy;
    logic          frame_done;
    logic          err_len;
    logic          err_sof;
    logic [2:0]    state_dbg;

    logic          rand_ds = 1'b0;
    logic [PW-1:0] exp_q[$];
    int            n_checks = 0;
    int            n_errors = 0;
    int            done_cnt = 0;
    int            pipe_cnt = 0;
    int            ce_frame = 0;
    int            cyc = 0;
    int            last_ce_cyc = -10;

    fast_frame_ctrl #(
        .COL_NUM      (COL),
        .ROW_NUM      (ROW),
        .PIXEL_WIDTH  (PW),
        .FLUSH_CYCLES (FLUSH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .cont       (cont),
        .s_data     (s_data),
        .s_valid    (s_valid),
        .s_sof      (s_sof),
        .s_eol      (s_eol),
        .s_ready    (s_ready),
        .ds_ready   (ds_ready),
        .ce         (ce),
        .pix_out    (pix_out),
        .pipe_rst   (pipe_rst),
        .busy       (busy),
        .frame_done (frame_done),
        .err_len    (err_len),
        .err_sof    (err_sof),
        .state_dbg  (state_dbg)
    );

    // Clock / reset-free watchdog
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // Downstream backpressure: sole driver of ds_ready.
    initial begin
        ds_ready = 1'b1;
        forever begin
            @(negedge clk);
            ds_ready = rand_ds ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor: pops the scoreboard on every ce, checks frame-level timing.
    initial begin
        logic [PW-1:0] exp;
        forever begin
            @(negedge clk);
            #4;
            cyc++;
            if (!rst) begin
                if (pipe_rst) begin
                    pipe_cnt++;
                    ce_frame = 0;
                end
                if (ce) begin
                    check("ce_needs_ds_ready", 32'(ds_ready), 32'd1);
                    if (exp_q.size() == 0) begin
                        check("pix_unexpected_ce", 32'(pix_out), 32'hffff_ffff);
                    end else begin
                        exp = exp_q.pop_front();
                        check("pix_out", 32'(pix_out), 32'(exp));
                    end
                    ce_frame++;
                    last_ce_cyc = cyc;
                end
                if (frame_done) begin
                    done_cnt++;
                    check("done_lag", 32'(cyc - last_ce_cyc), 32'd1);
                    check("frame_ce_total", 32'(ce_frame), 32'(NPIX + FLUSH));
                    ce_frame = 0;
                end
            end
        end
    end

    // Driver tasks
    task automatic send_beat(input logic [PW-1:0] d, input logic sof, input logic eol);
        bit got = 1'b0;
        @(negedge clk);
        s_data  = d;
        s_sof   = sof;
        s_eol   = eol;
        s_valid = 1'b1;
        for (int i = 0; i < 2000 && !got; i++) begin
            #4;
            if (s_ready) got = 1'b1;
            else @(negedge clk);
        end
        if (!got) check("beat_timeout", 32'd0, 32'd1);
    endtask

    task automatic end_beats();
        @(negedge clk);
        s_valid = 1'b0;
        s_sof   = 1'b0;
        s_eol   = 1'b0;
    endtask

    task automatic do_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
    endtask

    // Reference: frame of NPIX beats, SOF on beat 0, EOL on the last beat of
    // each line; optional corrupted markers or an abort before beat abort_k.
    task automatic send_frame(input int bad_eol_k, input int bad_sof_k, input int abort_k);
        logic [PW-1:0] d;
        logic          sof;
        logic          eol;
        for (int k = 0; k < NPIX; k++) begin
            if (k == abort_k) begin
                @(negedge clk);
                s_valid = 1'b0;
                abort   = 1'b1;
                start   = 1'b1;
                @(negedge clk);
                abort = 1'b0;
                start = 1'b0;
                #4;
                check("abort_busy", 32'(busy), 32'd0);
                check("abort_pipe_rst", 32'(pipe_rst), 32'd1);
                return;
            end
            d   = 8'($urandom);
            sof = (k == 0) || (k == bad_sof_k);
            eol = ((k % COL) == COL - 1) ^ (k == bad_eol_k);
            exp_q.push_back(d);
            if (k == NPIX - 1)
                for (int f = 0; f < FLUSH; f++) exp_q.push_back('0);
            send_beat(d, sof, eol);
        end
        end_beats();
    endtask

    task automatic wait_done(input int target);
        for (int i = 0; i < 3000 && done_cnt < target; i++) @(negedge clk);
        check("frame_done_count", 32'(done_cnt), 32'(target));
    endtask

    task automatic settle();
        repeat (3) @(negedge clk);
    endtask

    initial begin
        int p0;
        int d0;
        rst = 1'b1; start = 1'b0; abort = 1'b0; cont = 1'b0;
        s_data = '0; s_valid = 1'b0; s_sof = 1'b0; s_eol = 1'b0;
        repeat (3) @(negedge clk);
        #4;
        check("rst_ce", 32'(ce), 32'd0);
        check("rst_s_ready", 32'(s_ready), 32'd0);
        check("rst_pix_out", 32'(pix_out), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_frame_done", 32'(frame_done), 32'd0);
        check("rst_pipe_rst", 32'(pipe_rst), 32'd0);
        check("rst_err_len", 32'(err_len), 32'd0);
        check("rst_err_sof", 32'(err_sof), 32'd0);
        check("rst_state", 32'(state_dbg), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // 1: clean frame, no backpressure
        p0 = pipe_cnt;
        do_start();
        check("t1_busy", 32'(busy), 32'd1);
        send_frame(-1, -1, -1);
        wait_done(1);
        settle();
        check("t1_busy_end", 32'(busy), 32'd0);
        check("t1_pipe_rst", 32'(pipe_cnt - p0), 32'd1);
        check("t1_queue_empty", 32'(exp_q.size()), 32'd0);
        check("t1_err_len", 32'(err_len), 32'd0);

        // 2: random 50% downstream backpressure
        rand_ds = 1'b1;
        do_start();
        send_frame(-1, -1, -1);
        wait_done(2);
        rand_ds = 1'b0;
        settle();
        check("t2_queue_empty", 32'(exp_q.size()), 32'd0);
        check("t2_busy_end", 32'(busy), 32'd0);

        // 3: beats before SOF are dropped while armed
        do_start();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            s_data  = 8'($urandom);
            s_valid = 1'b1;
            s_sof   = 1'b0;
            s_eol   = 1'b0;
            #4;
            check("t3_drop_ready", 32'(s_ready), 32'd1);
            check("t3_drop_ce", 32'(ce), 32'd0);
        end
        send_frame(-1, -1, -1);
        wait_done(3);
        settle();
        check("t3_queue_empty", 32'(exp_q.size()), 32'd0);

        // 4: misplaced EOL at row 2 col 5
        do_start();
        send_frame(2 * COL + 5, -1, -1);
        wait_done(4);
        settle();
        check("t4_err_len", 32'(err_len), 32'd1);
        check("t4_err_sof", 32'(err_sof), 32'd0);
        check("t4_queue_empty", 32'(exp_q.size()), 32'd0);

        // 5: stray SOF then abort at beat 20
        do_start();
        check("t5_err_len_cleared", 32'(err_len), 32'd0);
        d0 = done_cnt;
        p0 = pipe_cnt;
        send_frame(-1, 10, 20);
        settle();
        check("t5_no_frame_done", 32'(done_cnt - d0), 32'd0);
        check("t5_pipe_rst", 32'(pipe_cnt - p0), 32'd1);
        check("t5_err_sof_kept", 32'(err_sof), 32'd1);
        check("t5_busy", 32'(busy), 32'd0);
        check("t5_queue_empty", 32'(exp_q.size()), 32'd0);

        // 6: continuous mode, two frames back to back
        cont = 1'b1;
        d0 = done_cnt;
        do_start();
        p0 = pipe_cnt;
        send_frame(-1, -1, -1);
        send_frame(-1, -1, -1);
        cont = 1'b0;
        wait_done(d0 + 2);
        settle();
        check("t6_frames", 32'(done_cnt - d0), 32'd2);
        check("t6_no_pipe_rst", 32'(pipe_cnt - p0), 32'd0);
        check("t6_busy_end", 32'(busy), 32'd0);
        check("t6_err_sof_cleared", 32'(err_sof), 32'd0);
        check("t6_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
